encoder8to3_stream: RTL and testbench



---
 rtl/encoder8to3_stream.sv | 124 ++++++++++++
 tb/tb_encoder8to3_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder8to3_stream.sv
// encoder8to3_stream: serialises every set bit of an 8-bit request vector
// into a stream of 3-bit indices over a valid/ready handshake, with a
// last-beat marker, a pending-count output and an empty-vector error pulse.
// Build option: define ENC_MSB_FIRST_EN to emit indices highest bit first
// (default is lowest bit first).
// All outputs are registered from next-state/next-pend, so no input reaches
// an output combinationally.
module encoder8to3_stream (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic [3:0] remaining,
    output logic       empty_err
);

    localparam int unsigned VEC_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [VEC_W-1:0]   pend;
    logic [VEC_W-1:0]   pend_nxt;
    logic               err_nxt;
    logic [IDX_W-1:0]   cur_idx;

    // Index of the bit emitted next from a pending vector
    function automatic logic [IDX_W-1:0] sel_idx(input logic [VEC_W-1:0] p);
        logic [IDX_W-1:0] idx;
        idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < int'(VEC_W); i++) begin
            if (p[i]) idx = IDX_W'(i);
        end
`else
        for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
            if (p[i]) idx = IDX_W'(i);
        end
`endif
        return idx;
    endfunction

    // Number of set bits in a pending vector
    function automatic logic [CNT_W-1:0] pop_cnt(input logic [VEC_W-1:0] p);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(VEC_W); i++) begin
            cnt = cnt + CNT_W'(p[i]);
        end
        return cnt;
    endfunction

    // State and pending-vector register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Next-state: accept in IDLE, retire one pending bit per EMIT handshake
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        err_nxt   = 1'b0;
        cur_idx   = sel_idx(pend);
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec != '0) begin
                        pend_nxt  = in_vec;
                        state_nxt = EMIT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_nxt = pend & ~(VEC_W'(1) << cur_idx);
                    if (pend_nxt == '0) state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                pend_nxt  = '0;
            end
        endcase
    end

    // Output register: decoded from the upcoming state and pend
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            remaining <= '0;
            empty_err <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == EMIT);
            out_idx   <= sel_idx(pend_nxt);
            out_last  <= (pop_cnt(pend_nxt) == CNT_W'(1));
            remaining <= pop_cnt(pend_nxt);
            empty_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_encoder8to3_stream.sv
// Testbench for encoder8to3_stream: queue-based reference model checked every
// cycle, a table of directed vectors, hand-written multi-cycle sequences and
// randomized traffic.
module tb_encoder8to3_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic [3:0] remaining;
    logic       empty_err;

    encoder8to3_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .remaining (remaining),
        .empty_err (empty_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of indices still to be emitted, plus error flag
    int   mq[$];
    logic m_err;
    bit   m_valid;

    // Observed beats (handshaken indices) and empty_err pulses
    int   got[$];
    int   err_seen;

    typedef struct {
        logic [7:0]      vec;
        int              nbeats;
        logic [7:0][2:0] seq;   // ascending order, element 0 first
    } row_t;

    row_t rows[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Indices of a vector in emission order
    function automatic void build(input logic [7:0] v, output int q[$]);
        q = {};
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
`ifdef ENC_MSB_FIRST_EN
                q.push_front(i);
`else
                q.push_back(i);
`endif
            end
        end
    endfunction

    // One clock cycle: check outputs against model, drive inputs, advance model
    task automatic step(input logic r, input logic v, input logic [7:0] vec, input logic ordy);
        int nq[$];
        @(negedge clk);
        if (m_valid) begin
            chk("in_ready",  32'(in_ready),  32'(mq.size() == 0));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("remaining", 32'(remaining), 32'(mq.size()));
            chk("empty_err", 32'(empty_err), 32'(m_err));
            if (mq.size() != 0) begin
                chk("out_idx",  32'(out_idx),  32'(mq[0]));
                chk("out_last", 32'(out_last), 32'(mq.size() == 1));
            end
        end
        if (empty_err === 1'b1) err_seen++;
        if (!r && out_valid === 1'b1 && ordy) got.push_back(int'(out_idx));
        rst       = r;
        in_valid  = v;
        in_vec    = vec;
        out_ready = ordy;
        m_err     = 1'b0;
        if (r) begin
            mq      = {};
            m_valid = 1'b1;
        end else if (mq.size() != 0) begin
            if (ordy) void'(mq.pop_front());
        end else if (v) begin
            if (vec == 8'h00) m_err = 1'b1;
            else begin
                build(vec, nq);
                mq = nq;
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 1'b1);
    endtask

    int pre;
    int exp_rem;
    int row_ok;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        m_err = 1'b0; m_valid = 1'b0; err_seen = 0;

        rows[0] = '{vec: 8'h20, nbeats: 1, seq: {21'd0, 3'd5}};
        rows[1] = '{vec: 8'hA4, nbeats: 3, seq: {15'd0, 3'd7, 3'd5, 3'd2}};
        rows[2] = '{vec: 8'h01, nbeats: 1, seq: {21'd0, 3'd0}};
        rows[3] = '{vec: 8'h80, nbeats: 1, seq: {21'd0, 3'd7}};
        rows[4] = '{vec: 8'h81, nbeats: 2, seq: {18'd0, 3'd7, 3'd0}};
        rows[5] = '{vec: 8'h00, nbeats: 0, seq: 24'd0};
        rows[6] = '{vec: 8'hFF, nbeats: 8, seq: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};

        // Reset held for two cycles, then released
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("reset_out_idx",  32'(out_idx),  32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);

        // Table-driven vectors with continuous out_ready
        foreach (rows[r]) begin
            got = {};
            err_seen = 0;
            step(1'b0, 1'b1, rows[r].vec, 1'b1);
            drain(10);
            chk("tbl_nbeats", 32'(got.size()), 32'(rows[r].nbeats));
            row_ok = 1;
            for (int j = 0; j < rows[r].nbeats && j < got.size(); j++) begin
`ifdef ENC_MSB_FIRST_EN
                if (got[j] != int'(rows[r].seq[rows[r].nbeats-1-j])) row_ok = 0;
`else
                if (got[j] != int'(rows[r].seq[j])) row_ok = 0;
`endif
            end
            chk("tbl_order", 32'(row_ok), 32'd1);
            chk("tbl_empty_err", 32'(err_seen), 32'(rows[r].nbeats == 0));
        end

        // Backpressure on 8'hFF at index 3, with in_vec churning during EMIT
`ifdef ENC_MSB_FIRST_EN
        pre = 4; exp_rem = 4;
`else
        pre = 3; exp_rem = 5;
`endif
        got = {};
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < pre; i++) step(1'b0, 1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'b0);
            chk("stall_idx", 32'(out_idx), 32'd3);
            chk("stall_rem", 32'(remaining), 32'(exp_rem));
        end
        drain(12);
        chk("bp_nbeats", 32'(got.size()), 32'd8);

        // Zero vector, then 8'h01 accepted straight after
        got = {};
        err_seen = 0;
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h01, 1'b1);
        chk("zero_err_pulse", 32'(empty_err), 32'd1);
        chk("zero_no_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("zero_err_once", 32'(empty_err), 32'd0);
        drain(4);
        chk("zero_follow_beats", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("zero_follow_idx", 32'(got[0]), 32'd0);

        // Back-to-back zero vectors each pulse empty_err
        err_seen = 0;
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        drain(2);
        chk("zero_b2b_pulses", 32'(err_seen), 32'd3);

        // Reset mid-burst after the index-5 handshake
`ifdef ENC_MSB_FIRST_EN
        pre = 3;
`else
        pre = 2;
`endif
        got = {};
        step(1'b0, 1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < pre; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pre_rst_last_idx", 32'(got.size() > 0 ? got[got.size()-1] : 99), 32'd5);
        step(1'b1, 1'b1, 8'h55, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_rem",   32'(remaining), 32'd0);
        chk("rst_mid_ready", 32'(in_ready),  32'd1);
        got = {};
        step(1'b0, 1'b1, 8'h08, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_rst_idx",  32'(out_idx),  32'd3);
        chk("post_rst_last", 32'(out_last), 32'd1);
        drain(3);
        chk("post_rst_beats", 32'(got.size()), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                 1'($urandom_range(0, 9) < 7));
        end
        drain(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
